// File: rtl/cla_pipe_addsub.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Define CLA_SUB_EN to enable subtraction (sub=1 computes a-b); otherwise sub is ignored.
module cla_pipe_addsub #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NG = WIDTH / 4;        // 4-bit lookahead groups
   localparam int NB = (NG + 15) / 16;   // 16-group lookahead blocks

   // Carry into position n of a 16-wide generate/propagate vector, as a flat
   // sum of products rather than a chain.
   function automatic logic la_carry(input logic [15:0] gv, input logic [15:0] pv,
                                     input logic ci, input int n);
      logic c;
      logic pr;
      c  = 1'b0;
      pr = 1'b1;
      for (int j = 15; j >= 0; j--) begin
         if (j < n) begin
            c  = c | (pr & gv[j]);
            pr = pr & pv[j];
         end
      end
      return c | (pr & ci);
   endfunction

   // ---------------- stage 1: operand conditioning and group P/G ----------
   logic [WIDTH-1:0] b_eff;
   logic             c0_eff;

`ifdef CLA_SUB_EN
   assign b_eff  = sub ? ~b : b;
   assign c0_eff = sub | cin;
`else
   logic unused_sub;
   assign b_eff      = b;
   assign c0_eff     = cin;
   assign unused_sub = sub;
`endif

   logic [WIDTH-1:0] p_in, g_in;
   logic [NG-1:0]    pg_in, gg_in;

   assign p_in = a ^ b_eff;
   assign g_in = a & b_eff;

   // NOTE: every variable driven in always_comb gets a value on every path,
   // otherwise synthesis infers a latch.
   always_comb begin
      pg_in = '0;
      gg_in = '0;
      for (int k = 0; k < NG; k++) begin
         pg_in[k] = &p_in[4*k +: 4];
         gg_in[k] = g_in[4*k+3]
                  | (p_in[4*k+3] & g_in[4*k+2])
                  | (p_in[4*k+3] & p_in[4*k+2] & g_in[4*k+1])
                  | (p_in[4*k+3] & p_in[4*k+2] & p_in[4*k+1] & g_in[4*k]);
      end
   end

   logic             s1_valid, s2_valid;
   logic             s1_en, s2_en;
   logic [WIDTH-1:0] s1_p, s1_g;
   logic [NG-1:0]    s1_pg, s1_gg;
   logic             s1_c0;

   assign s2_en     = !s2_valid | out_ready;
   assign s1_en     = !s1_valid | s2_en;
   assign in_ready  = s1_en;
   assign out_valid = s2_valid;

   // NOTE: sequential state uses non-blocking assignments only. Data registers
   // are reset as well because a cleared sum/cout/ovf is visible at the output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_p     <= '0;
         s1_g     <= '0;
         s1_pg    <= '0;
         s1_gg    <= '0;
         s1_c0    <= 1'b0;
      end else if (s1_en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_p  <= p_in;
            s1_g  <= g_in;
            s1_pg <= pg_in;
            s1_gg <= gg_in;
            s1_c0 <= c0_eff;
         end
      end
   end

   // ---------------- stage 2: carry resolution and sum -------------------
   logic [NB*16-1:0] pg_pad, gg_pad, grp_c;
   logic [15:0]      blk_g, blk_p;
   logic             blk_cin, cur;
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_d;
   logic             cout_d, ovf_d;

   always_comb begin
      // Padding groups propagate and never generate, so they are transparent.
      pg_pad           = '1;
      gg_pad           = '0;
      pg_pad[NG-1:0]   = s1_pg;
      gg_pad[NG-1:0]   = s1_gg;
      blk_g            = '0;
      blk_p            = '1;
      blk_cin          = 1'b0;
      grp_c            = '0;
      for (int k = 0; k < NB; k++) begin
         blk_g[k] = la_carry(gg_pad[16*k +: 16], pg_pad[16*k +: 16], 1'b0, 16);
         blk_p[k] = &pg_pad[16*k +: 16];
      end
      for (int k = 0; k < NB; k++) begin
         blk_cin = la_carry(blk_g, blk_p, s1_c0, k);
         for (int j = 0; j < 16; j++)
            grp_c[16*k+j] = la_carry(gg_pad[16*k +: 16], pg_pad[16*k +: 16], blk_cin, j);
      end
      // Inside each group the carry ripples from the group carry-in.
      carry = '0;
      cur   = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i % 4 == 0) cur = grp_c[i/4];
         carry[i] = cur;
         cur      = s1_g[i] | (s1_p[i] & cur);
      end
      carry[WIDTH] = cur;
      sum_d  = s1_p ^ carry[WIDTH-1:0];
      cout_d = carry[WIDTH];
      ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         ovf      <= 1'b0;
      end else if (s2_en) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            sum  <= sum_d;
            cout <= cout_d;
            ovf  <= ovf_d;
         end
      end
   end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Self-checking bench for cla_pipe_addsub (WIDTH=64): directed vectors, backpressure,
// async reset and randomized traffic against an arithmetic reference model.
module tb_cla_pipe_addsub;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int checks = 0;
   int errors = 0;

   logic [W+1:0] exp_q[$];   // {ovf, cout, sum}

   cla_pipe_addsub #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   // Reference: plain wide arithmetic; overflow when same-signed operands give a
   // result of the other sign.
   function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mc, input logic ms);
      logic [W-1:0] be;
      logic         c0;
      logic [W:0]   r;
      logic         o;
      be = mb;
      c0 = mc;
`ifdef CLA_SUB_EN
      if (ms) begin
         be = ~mb;
         c0 = 1'b1;
      end
`else
      if (ms) c0 = mc;
`endif
      r = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, c0};
      o = (ma[W-1] == be[W-1]) && (r[W-1] != ma[W-1]);
      return {o, r};
   endfunction

   // One clock cycle: drive at the falling edge, observe 1 ns later, return
   // after the rising edge where transfers take effect.
   task automatic tick(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic is, input logic ordy,
                       output logic acc, output logic ir, output logic ov, output logic ret,
                       output logic [W-1:0] rs, output logic rc, output logic ro);
      @(negedge clk);
      in_valid  = iv;
      a         = ia;
      b         = ib;
      cin       = ic;
      sub       = is;
      out_ready = ordy;
      #1;
      ir  = in_ready;
      ov  = out_valid;
      acc = iv & in_ready;
      ret = out_valid & ordy;
      rs  = sum;
      rc  = cout;
      ro  = ovf;
      @(posedge clk);
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({out_valid, sum, cout, ovf} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: out_valid=%b sum=%h cout=%b ovf=%b, expected all 0",
                  out_valid, sum, cout, ovf);
      end
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_add_vectors();
      logic [W-1:0] va [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
      logic [W-1:0] vb [3] = '{64'd1, 64'd1, 64'd0};
      logic         vc [3] = '{1'b0, 1'b0, 1'b1};
      logic [W-1:0] es [3] = '{64'd0, 64'h8000_0000_0000_0000, 64'h0000_0001_0000_0000};
      logic         ec [3] = '{1'b1, 1'b0, 1'b0};
      logic         eo [3] = '{1'b0, 1'b1, 1'b0};
      logic acc, ir, ov, ret, rc, ro;
      logic [W-1:0] rs;
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, va[i], vb[i], vc[i], 1'b0, 1'b1, acc, ir, ov, ret, rs, rc, ro);
         checks++;
         if (acc !== 1'b1) begin
            errors++;
            $display("FAIL add%0d_accept: in_ready=%b expected 1", i, ir);
         end
         tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, ir, ov, ret, rs, rc, ro);
         checks++;
         if (ov !== 1'b0) begin
            errors++;
            $display("FAIL add%0d_early: out_valid=%b expected 0 one cycle after accept", i, ov);
         end
         tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, ir, ov, ret, rs, rc, ro);
         checks++;
         if ({ov, rs, rc, ro} !== {1'b1, es[i], ec[i], eo[i]}) begin
            errors++;
            $display("FAIL add%0d_result: valid=%b sum=%h cout=%b ovf=%b expected 1 %h %b %b",
                     i, ov, rs, rc, ro, es[i], ec[i], eo[i]);
         end
      end
   endtask

`ifdef CLA_SUB_EN
   task automatic test_sub();
      logic [W-1:0] va [2] = '{64'd5, 64'd7};
      logic [W-1:0] vb [2] = '{64'd7, 64'd5};
      logic [W-1:0] es [2] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd2};
      logic         ec [2] = '{1'b0, 1'b1};
      logic acc, ir, ov, ret, rc, ro;
      logic [W-1:0] rs;
      for (int i = 0; i < 2; i++) begin
         // cin is driven to 1 on the first vector: it must be ignored when sub=1
         tick(1'b1, va[i], vb[i], (i == 0), 1'b1, 1'b1, acc, ir, ov, ret, rs, rc, ro);
         tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, ir, ov, ret, rs, rc, ro);
         tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, ir, ov, ret, rs, rc, ro);
         checks++;
         if ({ov, rs, rc, ro} !== {1'b1, es[i], ec[i], 1'b0}) begin
            errors++;
            $display("FAIL sub%0d_result: valid=%b sum=%h cout=%b ovf=%b expected 1 %h %b 0",
                     i, ov, rs, rc, ro, es[i], ec[i]);
         end
      end
   endtask
`endif

   task automatic test_backpressure();
      logic acc, ir, ov, ret, rc, ro;
      logic [W-1:0] rs;
      logic [W-1:0] got[$];
      logic sent3;
      tick(1'b1, 64'd1, 64'd1, 1'b0, 1'b0, 1'b0, acc, ir, ov, ret, rs, rc, ro);
      tick(1'b1, 64'd2, 64'd2, 1'b0, 1'b0, 1'b0, acc, ir, ov, ret, rs, rc, ro);
      checks++;
      if (acc !== 1'b1) begin
         errors++;
         $display("FAIL bp_second_accept: in_ready=%b expected 1", ir);
      end
      for (int k = 0; k < 3; k++) begin
         tick(1'b1, 64'd3, 64'd3, 1'b0, 1'b0, 1'b0, acc, ir, ov, ret, rs, rc, ro);
         checks++;
         if ({ir, ov, rs} !== {1'b0, 1'b1, 64'd2}) begin
            errors++;
            $display("FAIL bp_hold%0d: in_ready=%b out_valid=%b sum=%h expected 0 1 2",
                     k, ir, ov, rs);
         end
      end
      sent3 = 1'b0;
      for (int k = 0; k < 10 && !(sent3 && got.size() >= 3); k++) begin
         tick(!sent3, 64'd3, 64'd3, 1'b0, 1'b0, 1'b1, acc, ir, ov, ret, rs, rc, ro);
         if (acc) sent3 = 1'b1;
         if (ret) got.push_back(rs);
      end
      checks++;
      if (got.size() != 3 || got[0] !== 64'd2 || got[1] !== 64'd4 || got[2] !== 64'd6) begin
         errors++;
         $display("FAIL bp_drain: got %0d results (%p) expected 2,4,6", got.size(), got);
      end
      tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, ir, ov, ret, rs, rc, ro);
      checks++;
      if (ov !== 1'b0) begin
         errors++;
         $display("FAIL bp_no_duplicate: out_valid=%b expected 0 after drain", ov);
      end
   endtask

   task automatic test_async_reset();
      logic acc, ir, ov, ret, rc, ro;
      logic [W-1:0] rs;
      tick(1'b1, 64'd100, 64'd1, 1'b0, 1'b0, 1'b0, acc, ir, ov, ret, rs, rc, ro);
      tick(1'b1, 64'd200, 64'd1, 1'b0, 1'b0, 1'b0, acc, ir, ov, ret, rs, rc, ro);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, sum} !== {1'b0, 64'd0}) begin
         errors++;
         $display("FAIL rst_midflight: out_valid=%b sum=%h expected 0 0", out_valid, sum);
      end
      #3 rst = 1'b0;
      tick(1'b1, 64'd9, 64'd9, 1'b0, 1'b0, 1'b1, acc, ir, ov, ret, rs, rc, ro);
      tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, ir, ov, ret, rs, rc, ro);
      checks++;
      if (ov !== 1'b0) begin
         errors++;
         $display("FAIL rst_stale: out_valid=%b sum=%h expected no output yet", ov, rs);
      end
      tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, ir, ov, ret, rs, rc, ro);
      checks++;
      if ({ov, rs} !== {1'b1, 64'd18}) begin
         errors++;
         $display("FAIL rst_next_beat: out_valid=%b sum=%h expected 1 %h", ov, rs, 64'd18);
      end
   endtask

   task automatic test_random();
      logic acc, ir, ov, ret, rc, ro;
      logic [W-1:0] rs, ra, rb;
      logic iv, ordy, exp_ir;
      logic held;
      logic [W+1:0] held_val, front;
      logic [W-1:0] corner [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
                                    64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
      exp_q.delete();
      held = 1'b0;
      held_val = '0;
      for (int n = 0; n < 400; n++) begin
         iv   = ($urandom_range(3) != 0);
         ordy = ($urandom_range(2) != 0);
         ra   = ($urandom_range(4) == 0) ? corner[$urandom_range(3)] : {$urandom, $urandom};
         rb   = ($urandom_range(4) == 0) ? corner[$urandom_range(3)] : {$urandom, $urandom};
         exp_ir = (exp_q.size() < 2) || ordy;
         tick(iv, ra, rb, $urandom_range(1) == 1, $urandom_range(1) == 1, ordy,
              acc, ir, ov, ret, rs, rc, ro);
         checks++;
         if (ir !== exp_ir) begin
            errors++;
            $display("FAIL rnd_in_ready[%0d]: got %b expected %b (occupancy %0d)",
                     n, ir, exp_ir, exp_q.size());
         end
         if (exp_q.size() == 0) begin
            checks++;
            if (ov !== 1'b0) begin
               errors++;
               $display("FAIL rnd_spurious[%0d]: out_valid=%b with nothing in flight", n, ov);
            end
         end
         if (held) begin
            checks++;
            if ({ov, ro, rc, rs} !== {1'b1, held_val}) begin
               errors++;
               $display("FAIL rnd_hold[%0d]: valid=%b {ovf,cout,sum}=%h expected 1 %h",
                        n, ov, {ro, rc, rs}, held_val);
            end
         end
         held     = ov & !ordy;
         held_val = {ro, rc, rs};
         if (ret) begin
            front = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++;
            if ({ro, rc, rs} !== front) begin
               errors++;
               $display("FAIL rnd_result[%0d]: {ovf,cout,sum}=%h expected %h", n, {ro, rc, rs}, front);
            end
         end
         if (acc) exp_q.push_back(model(ra, rb, cin, sub));
      end
      for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
         tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, ir, ov, ret, rs, rc, ro);
         if (ret) begin
            front = exp_q.pop_front();
            checks++;
            if ({ro, rc, rs} !== front) begin
               errors++;
               $display("FAIL rnd_drain: {ovf,cout,sum}=%h expected %h", {ro, rc, rs}, front);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rnd_lost: %0d results never emerged, expected 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_add_vectors();
`ifdef CLA_SUB_EN
      test_sub();
`endif
      test_backpressure();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
